fft_output_serializer: RTL and testbench

Drains one 4-point FFT result frame, presented as four parallel 16-bit words, onto a single-word valid/ready stream. It sits at the output end of the FFT datapath, opposite the input bit-reversal stage. It emits bins in either natural index order or bit-reversed order (0,2,1,3), selected per frame. Back-to-back frames stream with no idle cycle between them.

---
 rtl/fft_output_serializer_if.sv | 29 ++
 rtl/fft_output_serializer.sv | 80 ++++++++
 tb/tb_fft_output_serializer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_output_serializer_if.sv
// Load-side frame bus and output-side word stream of the FFT output serializer.
// The slave modport is the serializer's view; master is the upstream/downstream side.
interface fft_output_serializer_if #(
  parameter int unsigned DATA_W = 16
);
  logic              load_valid;
  logic              load_ready;
  logic              bit_rev_mode;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_index;
  logic              out_last;
  logic              busy;

  modport slave (
    input  load_valid, bit_rev_mode, in0, in1, in2, in3, out_ready,
    output load_ready, out_data, out_valid, out_index, out_last, busy
  );

  modport master (
    output load_valid, bit_rev_mode, in0, in1, in2, in3, out_ready,
    input  load_ready, out_data, out_valid, out_index, out_last, busy
  );
endinterface

// File: rtl/fft_output_serializer.sv
// Drains a 4-word FFT frame onto a single-word valid/ready stream in natural
// or bit-reversed (0,2,1,3) bin order, with back-to-back frames and no bubble.
module fft_output_serializer #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  fft_output_serializer_if.slave  bus
);
  localparam int unsigned NUM_BINS = 4;
  localparam int unsigned CNT_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              m_q;
  logic [DATA_W-1:0] buf_q [NUM_BINS];

  logic              last_beat_c;
  logic              load_fire_c;
  logic              beat_fire_c;
  logic [CNT_W-1:0]  idx_c;

  // Refill is allowed on the cycle the final word of the current frame drains.
  assign last_beat_c    = (state_q == SEND) && (cnt_q == CNT_W'(NUM_BINS - 1));
  assign bus.load_ready = !rst && ((state_q == IDLE) || (last_beat_c && bus.out_ready));
  assign load_fire_c    = bus.load_valid && bus.load_ready;
  assign beat_fire_c    = (state_q == SEND) && bus.out_ready;

  // Bit-reversed mode swaps the two counter bits to walk 0,2,1,3.
  assign idx_c = m_q ? {cnt_q[0], cnt_q[1]} : cnt_q;

  assign bus.out_data  = buf_q[idx_c];
  assign bus.out_index = idx_c;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_last  = last_beat_c;
  assign bus.busy      = (state_q == SEND);

  // State, beat counter, order mode and frame buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= 1'b0;
      for (int k = 0; k < NUM_BINS; k++) buf_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_fire_c) begin
            buf_q[0] <= bus.in0;
            buf_q[1] <= bus.in1;
            buf_q[2] <= bus.in2;
            buf_q[3] <= bus.in3;
            m_q      <= bus.bit_rev_mode;
            cnt_q    <= '0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (load_fire_c) begin
            buf_q[0] <= bus.in0;
            buf_q[1] <= bus.in1;
            buf_q[2] <= bus.in2;
            buf_q[3] <= bus.in3;
            m_q      <= bus.bit_rev_mode;
            cnt_q    <= '0;
          end else if (beat_fire_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat_c) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_output_serializer.sv
// Self-checking bench for fft_output_serializer: directed scenarios and random
// traffic against a word-queue reference model of the output stream.
module tb_fft_output_serializer;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        idx;
    logic              last;
  } beat_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fft_output_serializer_if #(.DATA_W(DATA_W)) bus_if ();

  fft_output_serializer #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending output words in emission order.
  beat_t exp_q[$];

  logic              o_valid, o_lready, o_busy, o_last;
  logic [1:0]        o_index;
  logic [DATA_W-1:0] o_data;
  logic              e_valid, e_lready;
  beat_t             e_beat;
  logic [21:0]       obs, expv;

  // One clock: drive inputs, sample at negedge, advance the model at posedge.
  task automatic tick(input logic r, input logic lv, input logic md,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic ordy);
    logic [DATA_W-1:0] w [4];
    int ord [4];
    rst                 = r;
    bus_if.load_valid   = lv;
    bus_if.bit_rev_mode = md;
    bus_if.in0          = a;
    bus_if.in1          = b;
    bus_if.in2          = c;
    bus_if.in3          = d;
    bus_if.out_ready    = ordy;
    @(negedge clk);
    o_valid  = bus_if.out_valid;
    o_lready = bus_if.load_ready;
    o_busy   = bus_if.busy;
    o_last   = bus_if.out_last;
    o_index  = bus_if.out_index;
    o_data   = bus_if.out_data;
    e_valid  = (exp_q.size() > 0);
    e_beat   = e_valid ? exp_q[0] : '0;
    e_lready = !r && ((exp_q.size() == 0) || (exp_q.size() == 1 && ordy));
    obs  = {o_valid, o_lready, o_busy, e_valid ? {o_data, o_index, o_last} : 19'b0};
    expv = {e_valid, e_lready, e_valid, e_beat};
    @(posedge clk);
    if (r) begin
      exp_q.delete();
    end else begin
      if (e_valid && ordy) void'(exp_q.pop_front());
      if (lv && e_lready) begin
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        if (md) ord = '{0, 2, 1, 3};
        else    ord = '{0, 1, 2, 3};
        for (int k = 0; k < 4; k++)
          exp_q.push_back('{data: w[ord[k]], idx: 2'(ord[k]), last: (k == 3)});
      end
    end
    #1;
  endtask

  task automatic idle_cycle();
    tick(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 1'b1);
      checks++;
      if ({o_valid, o_lready, o_busy, o_last, o_index, o_data} !== {3'b000, 1'b0, 2'd0, 16'h0000}) begin
        errors++;
        $display("FAIL reset_hold%0d got v=%b rdy=%b busy=%b last=%b idx=%0d data=%h want all zero",
                 i, o_valid, o_lready, o_busy, o_last, o_index, o_data);
      end
    end
    tick(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    checks++;
    if (obs !== expv || o_lready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got %h want %h (load_ready=%b out_valid=%b)", obs, expv, o_lready, o_valid);
    end
  endtask

  task automatic test_order(input logic md, input string name);
    logic [DATA_W-1:0] seen [4];
    logic [DATA_W-1:0] want [4];
    int n = 0;
    if (md) want = '{16'h1111, 16'h3333, 16'h2222, 16'h4444};
    else    want = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    tick(1'b0, 1'b1, md, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 16'hDEAD, 16'hBEEF, 1'b1);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s_cycle%0d got %h want %h", name, i, obs, expv);
      end
      if (o_valid === 1'b1 && n < 4) begin seen[n] = o_data; n++; end
    end
    checks++;
    if (n !== 4 || seen !== want) begin
      errors++;
      $display("FAIL %s_sequence got n=%0d %h %h %h %h want %h %h %h %h",
               name, n, seen[0], seen[1], seen[2], seen[3], want[0], want[1], want[2], want[3]);
    end
  endtask

  task automatic test_backpressure();
    logic rdy [7];
    int vcnt = 0;
    int held = 0;
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tick(1'b0, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, rdy[i]);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL bp_cycle%0d got %h want %h", i, obs, expv);
      end
      if (o_valid === 1'b1) vcnt++;
      if (o_valid === 1'b1 && o_data === 16'h2222 && o_index === 2'd1) held++;
    end
    checks++;
    if (vcnt !== 6 || held !== 3) begin
      errors++;
      $display("FAIL bp_span got valid_cycles=%0d held=%0d want 6 and 3", vcnt, held);
    end
  endtask

  task automatic test_back_to_back();
    int vcnt = 0;
    tick(1'b0, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'b0, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 1'b1);
      checks++;
      if (obs !== expv || o_lready !== (i == 3)) begin
        errors++;
        $display("FAIL b2b_first%0d got %h want %h (load_ready=%b)", i, obs, expv, o_lready);
      end
      if (o_valid === 1'b1) vcnt++;
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
      checks++;
      if (obs !== expv || (i == 0 && o_data !== 16'h5555)) begin
        errors++;
        $display("FAIL b2b_second%0d got %h want %h (data=%h)", i, obs, expv, o_data);
      end
      if (o_valid === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt !== 8) begin
      errors++;
      $display("FAIL b2b_valid_span got %0d want 8", vcnt);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    idle_cycle();
    idle_cycle();
    tick(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      checks++;
      if (o_valid !== 1'b0 || obs !== expv) begin
        errors++;
        $display("FAIL rstmid_flush%0d got %h want %h (out_valid=%b data=%h)", i, obs, expv, o_valid, o_data);
      end
    end
    tick(1'b0, 1'b1, 1'b1, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC, 1'b1);
    idle_cycle();
    checks++;
    if (obs !== expv || o_index !== 2'd0 || o_data !== 16'h9999) begin
      errors++;
      $display("FAIL rstmid_restart got idx=%0d data=%h want idx=0 data=9999", o_index, o_data);
    end
    for (int i = 0; i < 4; i++) idle_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), 1'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 3) != 0));
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random_cycle%0d got %h want %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_order(1'b0, "natural");
    test_order(1'b1, "bitrev");
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
